// File: rtl/divided_clock_monitor_pkg.sv
// divided_clock_monitor_pkg: shared state encodings and saturation helper for the divided-clock monitor
package divided_clock_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GATE  = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   localparam int MAX_CNT_W = 32;

   function automatic logic [MAX_CNT_W-1:0] sat_max(input int w);
      return (w >= MAX_CNT_W) ? '1 : (MAX_CNT_W'(1) << w) - MAX_CNT_W'(1);
   endfunction

endpackage

// File: rtl/divided_clock_monitor_edge_sync_detect.sv
// edge_sync_detect: multi-stage synchroniser followed by a registered rising-edge pulse
module edge_sync_detect #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic init,
   input  logic d,
   output logic rise
);

   logic [STAGES-1:0] chain;
   logic              s_prev;

   always_ff @(posedge clk) begin
      if (init) begin
         chain  <= '0;
         s_prev <= 1'b0;
         rise   <= 1'b0;
      end else begin
         chain  <= {chain[STAGES-2:0], d};
         s_prev <= chain[STAGES-1];
         rise   <= chain[STAGES-1] & ~s_prev;
      end
   end

endmodule

// File: rtl/divided_clock_monitor.sv
// divided_clock_monitor: gated edge counter and edge-to-edge period meter for a divided clock
module divided_clock_monitor
   import divided_clock_monitor_pkg::*;
#(
   parameter int GATE_CYCLES = 1000,
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             init,
   input  logic             enable,
   input  logic             div_in,
   output logic [CNT_W-1:0] edge_count,
   output logic [CNT_W-1:0] period,
   output logic             meas_valid,
   output logic             no_signal,
   output logic             overflow
);

   localparam int               GW      = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GW-1:0]    LAST    = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

   state_t           state;
   logic [GW-1:0]    gate_cnt;
   logic [CNT_W-1:0] edge_acc;
   logic [CNT_W-1:0] per_acc;
   logic [CNT_W-1:0] period_last;
   logic             first_seen;
   logic             ovf;
   logic             rise;
   logic             edge_sat;
   logic             per_sat;
   logic             two;

   edge_sync_detect #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .init (init),
      .d    (div_in),
      .rise (rise)
   );

   assign edge_sat = edge_acc == CNT_MAX;
   assign per_sat  = per_acc == CNT_MAX;
   assign two      = edge_acc > CNT_W'(1);

   always_ff @(posedge clk) begin
      if (init) begin
         state       <= ST_IDLE;
         gate_cnt    <= '0;
         edge_acc    <= '0;
         per_acc     <= '0;
         period_last <= '0;
         first_seen  <= 1'b0;
         ovf         <= 1'b0;
         edge_count  <= '0;
         period      <= '0;
         meas_valid  <= 1'b0;
         no_signal   <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  state      <= ST_GATE;
                  gate_cnt   <= '0;
                  edge_acc   <= '0;
                  per_acc    <= '0;
                  first_seen <= 1'b0;
                  ovf        <= 1'b0;
               end
            end
            ST_GATE: begin
               gate_cnt <= gate_cnt + 1'b1;
               if (gate_cnt == LAST) state <= ST_LATCH;
               if (rise) begin
                  edge_acc   <= edge_sat ? edge_acc : edge_acc + 1'b1;
                  ovf        <= ovf | edge_sat;
                  per_acc    <= '0;
                  first_seen <= 1'b1;
                  if (first_seen) period_last <= per_sat ? per_acc : per_acc + 1'b1;
               end else if (first_seen) begin
                  per_acc <= per_sat ? per_acc : per_acc + 1'b1;
                  ovf     <= ovf | per_sat;
               end
            end
            ST_LATCH: begin
               // a rise arriving in this cycle belongs to no window and is dropped
               edge_count <= edge_acc;
               period     <= two ? period_last : '0;
               no_signal  <= ~two;
               overflow   <= ovf;
               meas_valid <= 1'b1;
               state      <= enable ? ST_GATE : ST_IDLE;
               gate_cnt   <= '0;
               edge_acc   <= '0;
               per_acc    <= '0;
               first_seen <= 1'b0;
               ovf        <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divided_clock_monitor.sv
// tb_divided_clock_monitor: randomized self-checking bench against a window-level reference model
module tb_divided_clock_monitor;

   localparam int G  = 100;
   localparam int HN = 32768;

   logic        clk = 1'b0;
   logic        init = 1'b1;
   logic        enable = 1'b0;
   logic        div_in = 1'b0;
   logic [15:0] edge16, per16;
   logic        mv16, ns16, ov16;
   logic [3:0]  edge4, per4;
   logic        mv4, ns4, ov4;
   logic [34:0] obs16, obs4;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int rst_at  = 0;
   bit hist [HN];
   int mode = 0, hi = 2, lo = 2, ph = 0;
   logic cval = 1'b0;

   always #5 clk = ~clk;

   divided_clock_monitor #(.GATE_CYCLES(G), .CNT_W(16), .SYNC_STAGES(2)) dut16 (
      .clk(clk), .init(init), .enable(enable), .div_in(div_in),
      .edge_count(edge16), .period(per16), .meas_valid(mv16), .no_signal(ns16), .overflow(ov16)
   );

   divided_clock_monitor #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .init(init), .enable(enable), .div_in(div_in),
      .edge_count(edge4), .period(per4), .meas_valid(mv4), .no_signal(ns4), .overflow(ov4)
   );

   assign obs16 = {edge16, per16, ns16, ov16, mv16};
   assign obs4  = {12'd0, edge4, 12'd0, per4, ns4, ov4, mv4};

   // posedge index and the div_in level the design sampled there
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cyc + 1 < HN) hist[cyc + 1] <= div_in;
      if (init) rst_at <= cyc + 1;
   end

   function automatic bit h(input int x);
      return (x < 0 || x <= rst_at || x >= HN) ? 1'b0 : hist[x];
   endfunction

   // window closed by the LATCH at posedge lat covers posedges lat-G .. lat-1; a level change
   // sampled at posedge n is credited at posedge n+3
   function automatic logic [34:0] model(input int lat, input int w);
      int rs[$];
      int mx, n, cnt, per;
      logic ov;
      mx = (1 << w) - 1;
      ov = 1'b0;
      for (int t = lat - G; t < lat; t++) if (h(t - 3) && !h(t - 4)) rs.push_back(t);
      n = rs.size();
      for (int i = 1; i < n; i++) if (rs[i] - rs[i-1] - 1 > mx) ov = 1'b1;
      if (n > 0 && lat - 1 - rs[n-1] > mx) ov = 1'b1;
      if (n > mx) ov = 1'b1;
      cnt = (n > mx) ? mx : n;
      per = (n < 2) ? 0 : ((rs[n-1] - rs[n-2] > mx) ? mx : rs[n-1] - rs[n-2]);
      return {16'(cnt), 16'(per), n < 2, ov, 1'b1};
   endfunction

   task automatic adv();
      @(negedge clk);
      div_in = (mode == 0) ? cval :
               (mode == 1) ? (((cyc + 1 + ph) % (hi + lo)) < hi) : 1'($urandom_range(0, 1));
   endtask

   task automatic run_to(input int target, output bit spur);
      spur = 1'b0;
      while (cyc < target) begin
         adv();
         if (cyc < target && (mv16 || mv4)) spur = 1'b1;
      end
   endtask

   task automatic do_reset();
      init = 1'b1;
      enable = 1'b0;
      repeat (3) adv();
      init = 1'b0;
   endtask

   task automatic enable_now(output int e);
      e = cyc + 1;
      enable = 1'b1;
   endtask

   task automatic test_reset();
      bit spur;
      init = 1'b1;
      enable = 1'b0;
      mode = 2;
      repeat (3) adv();
      n_tests++; if (obs16 !== 35'd0) begin n_fail++; $display("FAIL reset16: got %h want 0", obs16); end
      n_tests++; if (obs4 !== 35'd0) begin n_fail++; $display("FAIL reset4: got %h want 0", obs4); end
      init = 1'b0;
      run_to(cyc + 101, spur);
      n_tests++; if (spur !== 1'b0 || mv16 !== 1'b0) begin n_fail++; $display("FAIL reset_idle: strobe seen %0d, want none", spur); end
      n_tests++; if (obs16 !== 35'd0) begin n_fail++; $display("FAIL reset_hold: got %h want 0", obs16); end
   endtask

   task automatic test_div4();
      int e;
      bit spur;
      do_reset();
      mode = 1; hi = 2; lo = 2; ph = $urandom_range(0, 3);
      repeat (6) adv();
      enable_now(e);
      run_to(e + 101, spur);
      n_tests++; if (spur || obs16 !== model(cyc, 16)) begin n_fail++; $display("FAIL div4_model: got %h want %h spur %0d", obs16, model(cyc, 16), spur); end
      n_tests++; if ({edge16, per16, ns16, ov16} !== {16'd25, 16'd4, 2'b00}) begin n_fail++; $display("FAIL div4_const: got %0d/%0d/%b%b want 25/4/00", edge16, per16, ns16, ov16); end
      n_tests++; if (obs4 !== model(cyc, 4)) begin n_fail++; $display("FAIL div4_w4: got %h want %h", obs4, model(cyc, 4)); end
   endtask

   task automatic test_div16();
      int e;
      bit spur;
      do_reset();
      mode = 1; hi = 8; lo = 8; ph = $urandom_range(0, 15);
      repeat (6) adv();
      enable_now(e);
      for (int k = 1; k <= 3; k++) begin
         run_to(e + 101 * k, spur);
         n_tests++; if (spur || obs16 !== model(cyc, 16)) begin n_fail++; $display("FAIL div16_w%0d: got %h want %h spur %0d", k, obs16, model(cyc, 16), spur); end
         n_tests++; if (!(edge16 == 16'd6 || edge16 == 16'd7) || per16 !== 16'd16 || mv16 !== 1'b1) begin n_fail++; $display("FAIL div16_const%0d: got %0d/%0d want 6or7/16", k, edge16, per16); end
         n_tests++; if (obs4 !== model(cyc, 4)) begin n_fail++; $display("FAIL div16_w4_%0d: got %h want %h", k, obs4, model(cyc, 4)); end
      end
   endtask

   task automatic test_stuck();
      int e;
      bit spur;
      do_reset();
      mode = 0; cval = 1'b0;
      repeat (6) adv();
      enable_now(e);
      for (int k = 1; k <= 4; k++) begin
         if (k == 3) begin
            run_to(e + 101 * 2 + $urandom_range(5, 80), spur);
            cval = 1'b1;
         end
         run_to(e + 101 * k, spur);
         n_tests++; if (spur || obs16 !== model(cyc, 16)) begin n_fail++; $display("FAIL stuck_model%0d: got %h want %h", k, obs16, model(cyc, 16)); end
         if (k != 3) begin
            n_tests++; if ({edge16, per16, ns16, ov16, mv16} !== {32'd0, 3'b101}) begin n_fail++; $display("FAIL stuck_const%0d: got %h want 0/0/ns", k, obs16); end
         end
      end
   endtask

   task automatic test_overflow();
      int e;
      bit spur;
      do_reset();
      mode = 1; hi = 1; lo = 1; ph = $urandom_range(0, 1);
      repeat (6) adv();
      enable_now(e);
      run_to(e + 101, spur);
      n_tests++; if ({edge4, ov4, mv4} !== {4'd15, 2'b11}) begin n_fail++; $display("FAIL ovf_w4: got %0d ovf %b want 15 ovf 1", edge4, ov4); end
      n_tests++; if (obs4 !== model(cyc, 4)) begin n_fail++; $display("FAIL ovf_w4_model: got %h want %h", obs4, model(cyc, 4)); end
      n_tests++; if ({edge16, per16, ov16} !== {16'd50, 16'd2, 1'b0}) begin n_fail++; $display("FAIL ovf_w16: got %0d/%0d ovf %b want 50/2/0", edge16, per16, ov16); end
   endtask

   task automatic test_init_mid();
      int e, lat;
      bit spur;
      do_reset();
      mode = 1; hi = $urandom_range(1, 6); lo = $urandom_range(1, 6); ph = $urandom_range(0, 11);
      repeat (6) adv();
      enable_now(e);
      lat = e + 101;
      run_to(lat, spur);
      n_tests++; if (spur || obs16 !== model(cyc, 16)) begin n_fail++; $display("FAIL init_pre: got %h want %h", obs16, model(cyc, 16)); end
      run_to(lat + 50, spur);
      init = 1'b1;
      enable = 1'b0;
      adv();
      n_tests++; if (obs16 !== 35'd0 || obs4 !== 35'd0) begin n_fail++; $display("FAIL init_mid: got %h %h want 0", obs16, obs4); end
      init = 1'b0;
      run_to(cyc + 120, spur);
      n_tests++; if (spur !== 1'b0) begin n_fail++; $display("FAIL init_idle: strobe %0d want none", spur); end
      enable_now(e);
      run_to(e + 101, spur);
      n_tests++; if (spur || obs16 !== model(cyc, 16)) begin n_fail++; $display("FAIL init_fresh: got %h want %h", obs16, model(cyc, 16)); end
      n_tests++; if (obs4 !== model(cyc, 4)) begin n_fail++; $display("FAIL init_fresh4: got %h want %h", obs4, model(cyc, 4)); end
   endtask

   task automatic test_enable_drop();
      int e;
      bit spur;
      do_reset();
      mode = 1; hi = 3; lo = 2; ph = $urandom_range(0, 4);
      repeat (6) adv();
      enable_now(e);
      run_to(e + 30, spur);
      enable = 1'b0;
      run_to(e + 101, spur);
      n_tests++; if (spur || obs16 !== model(cyc, 16)) begin n_fail++; $display("FAIL drop_strobe: got %h want %h", obs16, model(cyc, 16)); end
      run_to(cyc + 250, spur);
      n_tests++; if (spur !== 1'b0) begin n_fail++; $display("FAIL drop_idle: strobe %0d want none", spur); end
   endtask

   task automatic test_back_to_back();
      int e;
      bit spur;
      for (int i = 0; i < 6; i++) begin
         do_reset();
         mode = $urandom_range(1, 2);
         hi = $urandom_range(1, 12); lo = $urandom_range(1, 12); ph = $urandom_range(0, 23);
         repeat (6) adv();
         enable_now(e);
         for (int k = 1; k <= 2; k++) begin
            if (k == 2 && i[0]) begin
               run_to(e + 101 + $urandom_range(1, 99), spur);
               enable = 1'b0;
            end
            run_to(e + 101 * k, spur);
            n_tests++; if (spur || obs16 !== model(cyc, 16)) begin n_fail++; $display("FAIL b2b%0d_%0d: got %h want %h", i, k, obs16, model(cyc, 16)); end
            n_tests++; if (obs4 !== model(cyc, 4)) begin n_fail++; $display("FAIL b2b4_%0d_%0d: got %h want %h", i, k, obs4, model(cyc, 4)); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_div4();
      test_div16();
      test_stuck();
      test_overflow();
      test_init_mid();
      test_enable_drop();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
